gol_controller: RTL and testbench
=================================

GOL_CONTROLLER -- requirements
Module: gol_controller

Interface
REQ-001 SHALL have parameter M, default 16: grid columns, which is also the row width.
REQ-002 SHALL have parameter N, default 16: grid rows; RW = max(1, clog2(N)).
REQ-003 SHALL have parameter GEN_W, default 16: generation counter width.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid_i, input, 1: command request.
REQ-007 SHALL have port cmd_ready_o, output, 1: command accept; a command transfers when cmd_valid_i and cmd_ready_o are both high.
REQ-008 SHALL have port cmd_op_i, input, 3: opcode 0 NOP, 1 RUN, 2 PAUSE, 3 STEP, 4 CLEAR, 5 LOAD; 6 and 7 act as NOP.
REQ-009 SHALL have port cmd_row_i, input, RW: LOAD row index.
REQ-010 SHALL have port cmd_data_i, input, M: LOAD row data.
REQ-011 SHALL have port period_i, input, 16: cycles between RUN steps minus 1; latched when RUN is accepted.
REQ-012 SHALL have port gen_limit_i, input, GEN_W: RUN halt limit, where 0 means unlimited; latched when RUN is accepted.
REQ-013 SHALL have port stable_i, input, 1: engine flag indicating next grid equals current grid.
REQ-014 SHALL have port step_o, output, 1: one-cycle pulse; the engine advances one generation.
REQ-015 SHALL have port wr_en_o, output, 1: engine row-write strobe.
REQ-016 SHALL have port wr_row_o, output, RW: row being written.
REQ-017 SHALL have port wr_data_o, output, M: row write data.
REQ-018 SHALL have port fsm_o, output, 2: current state, 0 IDLE, 1 RUN, 2 CLEAR.
REQ-019 SHALL have port gen_count_o, output, GEN_W: generations stepped.
REQ-020 SHALL have port halted_o, output, 1: sticky flag set by an auto-halt.

Function
REQ-021 SHALL register all outputs except cmd_ready_o; a command accepted in cycle t takes effect at cycle t+1.
REQ-022 SHALL drive cmd_ready_o = 1 in IDLE and RUN, and 0 in CLEAR.
REQ-023 SHALL, in IDLE, handle accepted commands as follows: RUN goes to RUN, clears the tick counter and clears halted_o; STEP pulses step_o once and increments gen_count_o; LOAD pulses wr_en_o once with wr_row_o = cmd_row_i, wr_data_o = cmd_data_i and clears gen_count_o and halted_o; CLEAR goes to CLEAR; PAUSE and NOP have no effect.
REQ-024 SHALL, in IDLE, issue STEP regardless of stable_i.
REQ-025 SHALL, in RUN, increment the tick counter each cycle; when the counter equals the latched period, it SHALL issue step_o, increment gen_count_o and reset the counter to 0.
REQ-026 SHALL, with a latched period of 0, issue step_o every cycle.
REQ-027 SHALL, in RUN, suppress a due step when stable_i = 1 in that cycle, and instead go to IDLE with halted_o set.
REQ-028 SHALL, in RUN, go to IDLE with halted_o set on the cycle after the step that makes gen_count_o equal a nonzero latched limit.
REQ-029 SHALL, in RUN, make an accepted PAUSE go to IDLE with no step issued that cycle even if a tick is due, so PAUSE beats the tick.
REQ-030 SHALL, in RUN, make an accepted CLEAR go to CLEAR with no step issued.
REQ-031 SHALL, in RUN, make accepted RUN, STEP and LOAD have no effect; they are consumed and dropped.
REQ-032 SHALL, in CLEAR, drive wr_en_o = 1 and wr_data_o = 0 for exactly N consecutive cycles with wr_row_o = 0..N-1.
REQ-033 SHALL, at the end of CLEAR, set gen_count_o = 0, clear halted_o and go to IDLE; cmd_ready_o SHALL return high the cycle after row N-1.
REQ-034 SHALL saturate gen_count_o at 2^GEN_W-1, with no wrap.
REQ-035 SHALL never assert step_o and wr_en_o in the same cycle.
REQ-036 SHALL ignore period_i and gen_limit_i changes while in RUN.

Reset
REQ-037 SHALL, while reset_n_i = 0, immediately force: fsm_o = IDLE, step_o = 0, wr_en_o = 0, wr_row_o = 0, wr_data_o = 0, gen_count_o = 0, halted_o = 0, tick counter = 0, latched period and limit = 0.
REQ-038 SHALL, on reset asserted mid-CLEAR or mid-RUN, abort the operation with no further writes or steps and no resumption after release.
REQ-039 SHALL accept commands on the first clock edge after reset_n_i deasserts.

Verification
REQ-040 SHALL be verified with: period_i = 3, gen_limit_i = 0, RUN, stable_i = 0 -> step_o pulses every 4 cycles; gen_count_o = 5 after 20 cycles.
REQ-041 SHALL be verified with: gen_limit_i = 2, period_i = 0, RUN -> two consecutive step_o pulses, then fsm_o = IDLE, halted_o = 1, gen_count_o = 2.
REQ-042 SHALL be verified with: RUN, then stable_i = 1 on a due-step cycle -> no step_o that cycle, fsm_o = IDLE, halted_o = 1.
REQ-043 SHALL be verified with: CLEAR with N = 16 -> cmd_ready_o low for 16 cycles; wr_row_o = 0..15 with data 0; then gen_count_o = 0 and fsm_o = IDLE.
REQ-044 SHALL be verified with: LOAD row 3 data 0x0007, then STEP -> wr_en_o pulse (row 3, 0x0007) followed by one step_o pulse; gen_count_o = 1.
REQ-045 SHALL be verified with: PAUSE accepted on a tick-due cycle at period_i = 0 -> no step_o issued; reset_n_i pulsed low during CLEAR row 5 -> wr_en_o = 0 immediately and no writes after release.

Source files
------------

// File: rtl/gol_controller.sv
// Game-of-Life sequencing controller: turns RUN/STEP/PAUSE/CLEAR/LOAD commands
// into engine step pulses and row writes, with auto-halt on stability or generation limit.
module gol_controller #(
    parameter int M     = 16,
    parameter int N     = 16,
    parameter int GEN_W = 16,
    localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [RW-1:0]    cmd_row_i,
    input  logic [M-1:0]     cmd_data_i,
    input  logic [15:0]      period_i,
    input  logic [GEN_W-1:0] gen_limit_i,
    input  logic             stable_i,
    output logic             step_o,
    output logic             wr_en_o,
    output logic [RW-1:0]    wr_row_o,
    output logic [M-1:0]     wr_data_o,
    output logic [1:0]       fsm_o,
    output logic [GEN_W-1:0] gen_count_o,
    output logic             halted_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_PAUSE = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;
    localparam logic [2:0] OP_LOAD  = 3'd5;

    state_t             state_r;
    logic [15:0]        tick_r;
    logic [15:0]        period_r;
    logic [GEN_W-1:0]   limit_r;
    logic               cmd_fire_s;
    logic [GEN_W-1:0]   gen_next_s;
    logic               limit_hit_s;

    assign cmd_ready_o = (state_r != ST_CLEAR);
    assign fsm_o       = state_r;

    // Command handshake, saturating generation increment and limit detection.
    always_comb begin
        cmd_fire_s  = cmd_valid_i & cmd_ready_o;
        gen_next_s  = gen_count_o;
        limit_hit_s = 1'b0;
        if (gen_count_o != {GEN_W{1'b1}}) begin
            gen_next_s = gen_count_o + {{(GEN_W-1){1'b0}}, 1'b1};
        end else begin
            gen_next_s = gen_count_o;
        end
        // step_o high in RUN means the previous cycle stepped and produced this count
        if (step_o && (limit_r != {GEN_W{1'b0}}) && (gen_count_o == limit_r)) begin
            limit_hit_s = 1'b1;
        end else begin
            limit_hit_s = 1'b0;
        end
    end

    // Controller state machine with registered engine outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= ST_IDLE;
            tick_r      <= 16'd0;
            period_r    <= 16'd0;
            limit_r     <= {GEN_W{1'b0}};
            step_o      <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_row_o    <= {RW{1'b0}};
            wr_data_o   <= {M{1'b0}};
            gen_count_o <= {GEN_W{1'b0}};
            halted_o    <= 1'b0;
        end else begin
            step_o  <= 1'b0;
            wr_en_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        case (cmd_op_i)
                            OP_RUN: begin
                                state_r  <= ST_RUN;
                                tick_r   <= 16'd0;
                                halted_o <= 1'b0;
                                period_r <= period_i;
                                limit_r  <= gen_limit_i;
                            end
                            OP_STEP: begin
                                step_o      <= 1'b1;
                                gen_count_o <= gen_next_s;
                            end
                            OP_CLEAR: begin
                                state_r   <= ST_CLEAR;
                                wr_en_o   <= 1'b1;
                                wr_row_o  <= {RW{1'b0}};
                                wr_data_o <= {M{1'b0}};
                            end
                            OP_LOAD: begin
                                wr_en_o     <= 1'b1;
                                wr_row_o    <= cmd_row_i;
                                wr_data_o   <= cmd_data_i;
                                gen_count_o <= {GEN_W{1'b0}};
                                halted_o    <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cmd_fire_s && (cmd_op_i == OP_PAUSE)) begin
                        state_r <= ST_IDLE;
                    end else if (cmd_fire_s && (cmd_op_i == OP_CLEAR)) begin
                        state_r   <= ST_CLEAR;
                        wr_en_o   <= 1'b1;
                        wr_row_o  <= {RW{1'b0}};
                        wr_data_o <= {M{1'b0}};
                    end else if (limit_hit_s) begin
                        state_r  <= ST_IDLE;
                        halted_o <= 1'b1;
                    end else if (tick_r == period_r) begin
                        tick_r <= 16'd0;
                        if (stable_i) begin
                            state_r  <= ST_IDLE;
                            halted_o <= 1'b1;
                        end else begin
                            step_o      <= 1'b1;
                            gen_count_o <= gen_next_s;
                        end
                    end else begin
                        tick_r <= tick_r + 16'd1;
                    end
                end
                ST_CLEAR: begin
                    // wr_row_o doubles as the sweep counter
                    if (wr_row_o == RW'(N - 1)) begin
                        state_r     <= ST_IDLE;
                        gen_count_o <= {GEN_W{1'b0}};
                        halted_o    <= 1'b0;
                    end else begin
                        wr_en_o   <= 1'b1;
                        wr_row_o  <= wr_row_o + {{(RW-1){1'b0}}, 1'b1};
                        wr_data_o <= {M{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gol_controller.sv
// Self-checking bench for gol_controller: directed scenarios plus random commands
// compared every cycle against a behavioural command-level model.
module tb_gol_controller;

    localparam int M     = 16;
    localparam int N     = 16;
    localparam int GEN_W = 16;
    localparam int GMAX  = (1 << GEN_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [3:0]  cmd_row = 4'd0;
    logic [15:0] cmd_data = 16'd0;
    logic [15:0] period = 16'd0;
    logic [15:0] gen_limit = 16'd0;
    logic        stable = 1'b0;
    logic        step;
    logic        wr_en;
    logic [3:0]  wr_row;
    logic [15:0] wr_data;
    logic [1:0]  fsm;
    logic [15:0] gen_count;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;
    int steps_seen = 0;
    int ready_low_seen = 0;
    int writes_seen = 0;

    // model state: mode 0 idle, 1 running, 2 clearing
    int m_mode, m_tick, m_period, m_limit, m_gen, m_row, m_data;
    bit m_halt, m_step, m_wen, m_pend;
    int clr_q[$];

    gol_controller #(.M(M), .N(N), .GEN_W(GEN_W)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_row_i(cmd_row), .cmd_data_i(cmd_data),
        .period_i(period), .gen_limit_i(gen_limit), .stable_i(stable),
        .step_o(step), .wr_en_o(wr_en), .wr_row_o(wr_row), .wr_data_o(wr_data),
        .fsm_o(fsm), .gen_count_o(gen_count), .halted_o(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int g);
        return (g == GMAX) ? g : g + 1;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_tick = 0; m_period = 0; m_limit = 0; m_gen = 0;
        m_row = 0; m_data = 0; m_halt = 0; m_step = 0; m_wen = 0; m_pend = 0;
        clr_q.delete();
    endfunction

    function automatic void start_clear();
        clr_q.delete();
        for (int i = 0; i < N; i++) clr_q.push_back(i);
        m_mode = 2;
        m_row  = clr_q.pop_front();
        m_data = 0;
        m_wen  = 1;
    endfunction

    function automatic void model_edge();
        bit fire;
        bit pend;
        int op;
        fire = cmd_valid && (m_mode != 2);
        op = int'(cmd_op);
        pend = m_pend;
        m_pend = 0; m_step = 0; m_wen = 0;
        case (m_mode)
            0: if (fire) begin
                case (op)
                    1: begin m_mode = 1; m_tick = 0; m_halt = 0;
                             m_period = int'(period); m_limit = int'(gen_limit); end
                    3: begin m_step = 1; m_gen = sat_inc(m_gen); end
                    4: start_clear();
                    5: begin m_wen = 1; m_row = int'(cmd_row); m_data = int'(cmd_data);
                             m_gen = 0; m_halt = 0; end
                    default: ;
                endcase
            end
            1: begin
                if (fire && op == 2) m_mode = 0;
                else if (fire && op == 4) start_clear();
                else if (pend) begin m_mode = 0; m_halt = 1; end
                else if (m_tick == m_period) begin
                    m_tick = 0;
                    if (stable) begin m_mode = 0; m_halt = 1; end
                    else begin
                        m_step = 1;
                        m_gen = sat_inc(m_gen);
                        m_pend = (m_limit != 0) && (m_gen == m_limit);
                    end
                end else m_tick++;
            end
            2: begin
                if (clr_q.size() == 0) begin m_mode = 0; m_gen = 0; m_halt = 0; end
                else begin m_row = clr_q.pop_front(); m_data = 0; m_wen = 1; end
            end
            default: ;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".fsm"}, fsm, m_mode);
        chk({tag, ".step"}, step, m_step);
        chk({tag, ".wr_en"}, wr_en, m_wen);
        chk({tag, ".wr_row"}, wr_row, m_row);
        chk({tag, ".wr_data"}, wr_data, m_data);
        chk({tag, ".gen"}, gen_count, m_gen);
        chk({tag, ".halted"}, halted, m_halt);
        chk({tag, ".ready"}, cmd_ready, (m_mode != 2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all("cyc");
        if (step) steps_seen++;
        if (!cmd_ready) ready_low_seen++;
        if (wr_en) writes_seen++;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [3:0] row, input logic [15:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();

        // steady run at period 3
        period = 16'd3; gen_limit = 16'd0; stable = 1'b0;
        cmd(3'd1, 4'd0, 16'd0);
        steps_seen = 0;
        repeat (20) tick();
        chk("run_p3.steps", steps_seen, 5);
        chk("run_p3.gen", gen_count, 5);
        cmd(3'd2, 4'd0, 16'd0);

        // generation limit of 2 at period 0
        cmd(3'd5, 4'd0, 16'd0);
        period = 16'd0; gen_limit = 16'd2;
        cmd(3'd1, 4'd0, 16'd0);
        steps_seen = 0;
        repeat (5) tick();
        chk("limit.steps", steps_seen, 2);
        chk("limit.fsm", fsm, 0);
        chk("limit.halted", halted, 1);
        chk("limit.gen", gen_count, 2);

        // stable grid halts on the due step
        period = 16'd1; gen_limit = 16'd0; stable = 1'b1;
        cmd(3'd1, 4'd0, 16'd0);
        steps_seen = 0;
        repeat (4) tick();
        chk("stable.steps", steps_seen, 0);
        chk("stable.fsm", fsm, 0);
        chk("stable.halted", halted, 1);
        stable = 1'b0;

        // full clear
        ready_low_seen = 0; writes_seen = 0;
        cmd(3'd4, 4'd0, 16'd0);
        repeat (18) tick();
        chk("clear.ready_low", ready_low_seen, N);
        chk("clear.writes", writes_seen, N);
        chk("clear.gen", gen_count, 0);
        chk("clear.fsm", fsm, 0);

        // load then single step
        cmd(3'd5, 4'd3, 16'h0007);
        chk("load.row", wr_row, 3);
        chk("load.data", wr_data, 16'h0007);
        cmd(3'd3, 4'd0, 16'd0);
        chk("step.pulse", step, 1);
        chk("step.gen", gen_count, 1);

        // pause beats a due tick
        period = 16'd0;
        cmd(3'd1, 4'd0, 16'd0);
        steps_seen = 0;
        cmd(3'd2, 4'd0, 16'd0);
        tick();
        chk("pause.steps", steps_seen, 0);

        // reset during clear row 5
        cmd(3'd4, 4'd0, 16'd0);
        repeat (5) tick();
        chk("clr5.row", wr_row, 5);
        do_reset();
        chk("clr5.wr_en", wr_en, 0);
        writes_seen = 0;
        repeat (20) tick();
        chk("clr5.no_writes", writes_seen, 0);

        // random commands against the model
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_row   = 4'($urandom_range(0, 15));
            cmd_data  = 16'($urandom);
            period    = 16'($urandom_range(0, 4));
            gen_limit = 16'($urandom_range(0, 6));
            stable    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
